ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: event FIFO entries; power of 2, >=2.
REQ-002 Parameter CNT_WIDTH, default 8: width of the press counter.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ps2_data  in  8  received PS/2 byte; sampled only when ps2_valid=1.
REQ-006 ps2_valid  in  1  one-cycle strobe per received byte.
REQ-007 ev_valid  out  1  FIFO head holds an event.
REQ-008 ev_ready  in  1  consumer accepts the head when ev_valid&ev_ready.
REQ-009 ev_code  out  8  scancode of the head event, prefixes stripped.
REQ-010 ev_ext  out  1  head event was E0-prefixed.
REQ-011 ev_break  out  1  head event is a release.
REQ-012 ev_repeat  out  1  head event is a typematic repeat make.
REQ-013 ev_ascii  out  8  ASCII of the head event, 00 if unmapped.
REQ-014 ev_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 ev_overflow  out  1  sticky: an event was dropped.
REQ-016 shift_flag, ctrl_flag, alt_flag, caps_lock  out  1 each  modifier state.
REQ-017 disp_en  out  1  a non-modifier key is currently held.
REQ-018 disp_code, disp_ascii  out  8 each  code and ASCII of the last non-repeat, non-modifier make.
REQ-019 key_cnt  out  CNT_WIDTH  count of non-repeat make events.

Function
REQ-020 Parser FSM states IDLE, EXT, BRK, EXT_BRK; advances only on ps2_valid.
REQ-021 IDLE: E0->EXT; F0->BRK; other byte->emit make (ext=0), stay IDLE.
REQ-022 EXT: F0->EXT_BRK; other byte->emit make (ext=1), go IDLE.
REQ-023 BRK: any byte->emit break (ext=0), go IDLE; EXT_BRK: any byte->emit break (ext=1), go IDLE.
REQ-024 Emitted event is pushed into FIFO at the clock edge ending the final-byte ps2_valid cycle; ev_valid high the next cycle (first-word-fall-through).
REQ-025 Modifier flags, disp_*, key_cnt update at the same edge as the push.
REQ-026 shift_flag = left (12) held OR right (59) held, tracked separately; ctrl_flag = 14 (ext or not); alt_flag = 11 (ext or not); set on make, clear on matching break.
REQ-027 caps_lock toggles on non-repeat make of 58 only; unchanged on break or repeat.
REQ-028 Held key: make of non-modifier code sets held_code/held_ext; repeat = make matching current held_code/held_ext while held; matching break clears held; non-matching break leaves held.
REQ-029 Repeat makes are pushed with ev_repeat=1 but do not change key_cnt, caps_lock or disp_*.
REQ-030 ASCII (non-ext only): 1C..1A letter codes -> 'a'..'z', uppercase if shift_flag XOR caps_lock, using modifier state before the event; 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0'; 29->20; 5A->0D; ext or unmapped -> 00; break events carry same mapping.
REQ-031 key_cnt increments by 1 per non-repeat make, wraps modulo 2^CNT_WIDTH.
REQ-032 FIFO full and push without pop: event dropped, ev_overflow set, FIFO unchanged; modifier/held/count state still updates.
REQ-033 Full with simultaneous push and pop: both take effect, level unchanged, no overflow.
REQ-034 Empty: ev_ready ignored, level stays 0; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-035 rst at any cycle, including mid-prefix: FSM->IDLE, partial sequence discarded, FIFO emptied.
REQ-036 All outputs reset to 0: ev_valid, ev_*, ev_level, ev_overflow, all modifier flags, caps_lock, disp_en, disp_code, disp_ascii, key_cnt.
REQ-037 rst has priority over ps2_valid and ev_ready in the same cycle.

Verification
REQ-038 Bytes 1C,F0,1C, ev_ready=1 -> make {1C,ext0,ascii 61}, break {1C,ascii 61}; key_cnt=1; disp_en 1 then 0.
REQ-039 12,1C,1C,F0,1C,F0,12 -> 'A'(41) make, repeat=1 second make, key_cnt=2 (12 and 1C), shift_flag 1 then 0.
REQ-040 58,F0,58,1C -> caps_lock=1, 1C event ascii 41; E0,F0,14 after E0,14 -> ctrl_flag 1 then 0, events ext=1 ascii 00.
REQ-041 ev_ready=0, FIFO_DEPTH+1 make events -> level=FIFO_DEPTH, ev_overflow=1, first FIFO_DEPTH events drained in order.
REQ-042 E0 then rst then 1C -> make 1C with ext=0; all outputs 0 during and after reset until the event.

Source files
------------

// File: rtl/ps2_key_if.sv
// Byte input and key-event output of the PS/2 key decoder.
//
// Handshake rules:
//   ps2_valid : single-cycle strobe; ps2_data is meaningful only while it is
//               high. There is no back-pressure on this side. Every strobe is
//               taken at once.
//   ev_valid / ev_ready : the head event (ev_code, ev_ext, ev_break,
//               ev_repeat, ev_ascii) is stable while ev_valid is high. It is
//               consumed on a rising edge where ev_valid && ev_ready. ev_ready
//               may be asserted at any time; it has no effect while ev_valid
//               is low.
interface ps2_key_if;
   logic [7:0] ps2_data;
   logic       ps2_valid;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_repeat;
   logic [7:0] ev_ascii;

   // Side that feeds bytes and consumes events.
   modport master (
      output ps2_data, ps2_valid, ev_ready,
      input  ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii
   );

   // The decoder.
   modport slave (
      input  ps2_data, ps2_valid, ev_ready,
      output ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder. Prefix bytes (E0, F0) are folded into one
// event per key action. Each event is tagged with an ASCII translation and a
// typematic-repeat flag, then queued in a first-word-fall-through FIFO.
// Modifier flags, caps lock, the held-key display and a press counter are
// kept next to the queue. They update on the same edge an event is emitted,
// whether or not the FIFO has room for it.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   ps2_key_if.slave                    bus,
   output logic [$clog2(FIFO_DEPTH):0] ev_level,
   output logic                        ev_overflow,
   output logic                        shift_flag,
   output logic                        ctrl_flag,
   output logic                        alt_flag,
   output logic                        caps_lock,
   output logic                        disp_en,
   output logic [7:0]                  disp_code,
   output logic [7:0]                  disp_ascii,
   output logic [CNT_WIDTH-1:0]        key_cnt,
   output logic [1:0]                  state_dbg
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;
   localparam logic [7:0] K_LSHIFT = 8'h12;
   localparam logic [7:0] K_RSHIFT = 8'h59;
   localparam logic [7:0] K_CTRL   = 8'h14;
   localparam logic [7:0] K_ALT    = 8'h11;
   localparam logic [7:0] K_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] ascii;
   } ev_t;

   // Set-2 scancode to ASCII. Only non-extended letters, digits, space and
   // enter are mapped. Letters are uppercased when 'upper' is set.
   function automatic logic [7:0] map_ascii(input logic [7:0] code,
                                            input logic       ext,
                                            input logic       upper);
      logic [7:0] lc;
      logic [7:0] res;
      lc  = 8'h00;
      res = 8'h00;
      if (!ext) begin
         case (code)
            8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63;
            8'h23: lc = 8'h64; 8'h24: lc = 8'h65; 8'h2B: lc = 8'h66;
            8'h34: lc = 8'h67; 8'h33: lc = 8'h68; 8'h43: lc = 8'h69;
            8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F;
            8'h4D: lc = 8'h70; 8'h15: lc = 8'h71; 8'h2D: lc = 8'h72;
            8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74; 8'h3C: lc = 8'h75;
            8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
            8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
            default: lc = 8'h00;
         endcase
         if (lc != 8'h00) begin
            res = upper ? (lc - 8'h20) : lc;
         end else begin
            case (code)
               8'h16: res = 8'h31; 8'h1E: res = 8'h32; 8'h26: res = 8'h33;
               8'h25: res = 8'h34; 8'h2E: res = 8'h35; 8'h36: res = 8'h36;
               8'h3D: res = 8'h37; 8'h3E: res = 8'h38; 8'h46: res = 8'h39;
               8'h45: res = 8'h30;
               8'h29: res = 8'h20;
               8'h5A: res = 8'h0D;
               default: res = 8'h00;
            endcase
         end
      end
      return res;
   endfunction

   // ---------------- prefix parser ----------------
   state_t state_q, state_d;
   logic   emit, emit_ext, emit_brk;

   // Parser state register; reset abandons any partial prefix sequence.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Parser next state and one-cycle emit strobe with the event's flags.
   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (bus.ps2_valid) begin
         case (state_q)
            S_IDLE: begin
               if (bus.ps2_data == PFX_EXT)      state_d = S_EXT;
               else if (bus.ps2_data == PFX_BRK) state_d = S_BRK;
               else                              emit    = 1'b1;
            end
            S_EXT: begin
               if (bus.ps2_data == PFX_BRK) begin
                  state_d = S_EXT_BRK;
               end else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_BRK: begin
               emit     = 1'b1;
               emit_brk = 1'b1;
               state_d  = S_IDLE;
            end
            S_EXT_BRK: begin
               emit     = 1'b1;
               emit_ext = 1'b1;
               emit_brk = 1'b1;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign state_dbg = state_q;

   // ---------------- key state ----------------
   logic       shift_l, shift_r;
   logic       held_v, held_ext;
   logic [7:0] held_code;

   logic       is_lshift, is_rshift, is_ctrl, is_alt, is_caps, is_mod;
   logic       held_match, is_rep;
   logic [7:0] ev_asc;
   ev_t        new_ev;

   // Classify the byte that completes the event. ASCII is taken from the
   // modifier state as it was before this event.
   always_comb begin
      is_lshift  = (bus.ps2_data == K_LSHIFT);
      is_rshift  = (bus.ps2_data == K_RSHIFT);
      is_ctrl    = (bus.ps2_data == K_CTRL);
      is_alt     = (bus.ps2_data == K_ALT);
      is_caps    = (bus.ps2_data == K_CAPS);
      is_mod     = is_lshift | is_rshift | is_ctrl | is_alt | is_caps;
      held_match = held_v && (held_code == bus.ps2_data) && (held_ext == emit_ext);
      is_rep     = !emit_brk && !is_mod && held_match;
      ev_asc     = map_ascii(bus.ps2_data, emit_ext, shift_flag ^ caps_lock);
      new_ev     = '{code: bus.ps2_data, ext: emit_ext, brk: emit_brk,
                     rep: is_rep, ascii: ev_asc};
   end

   // Modifier, held-key, display and counter updates on every emitted event.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_l    <= 1'b0;
         shift_r    <= 1'b0;
         ctrl_flag  <= 1'b0;
         alt_flag   <= 1'b0;
         caps_lock  <= 1'b0;
         held_v     <= 1'b0;
         held_ext   <= 1'b0;
         held_code  <= 8'h00;
         disp_code  <= 8'h00;
         disp_ascii <= 8'h00;
         key_cnt    <= '0;
      end else if (emit) begin
         if (!emit_brk) begin
            if (is_lshift) shift_l   <= 1'b1;
            if (is_rshift) shift_r   <= 1'b1;
            if (is_ctrl)   ctrl_flag <= 1'b1;
            if (is_alt)    alt_flag  <= 1'b1;
            if (is_caps)   caps_lock <= ~caps_lock;
            if (!is_rep)   key_cnt   <= key_cnt + CNT_WIDTH'(1);
            if (!is_mod && !is_rep) begin
               held_v     <= 1'b1;
               held_code  <= bus.ps2_data;
               held_ext   <= emit_ext;
               disp_code  <= bus.ps2_data;
               disp_ascii <= ev_asc;
            end
         end else begin
            if (is_lshift)  shift_l   <= 1'b0;
            if (is_rshift)  shift_r   <= 1'b0;
            if (is_ctrl)    ctrl_flag <= 1'b0;
            if (is_alt)     alt_flag  <= 1'b0;
            if (held_match) held_v    <= 1'b0;
         end
      end
   end

   assign shift_flag = shift_l | shift_r;
   assign disp_en    = held_v;

   // ---------------- event FIFO ----------------
   ev_t           mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count_q;
   logic          empty, full, pop, push_ok;
   ev_t           head;

   assign empty   = (count_q == '0);
   assign full    = (count_q == LW'(FIFO_DEPTH));
   assign pop     = !empty && bus.ev_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok = emit && (!full || pop);

   // Event storage; contents only matter where the pointers say so.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= new_ev;
   end

   // Pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         ev_overflow <= 1'b0;
      end else begin
         if (push_ok)         wr_ptr      <= wr_ptr + AW'(1);
         if (pop)             rd_ptr      <= rd_ptr + AW'(1);
         if (emit && !push_ok) ev_overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + LW'(1);
            2'b01:   count_q <= count_q - LW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Head fields read as zero whenever the FIFO is empty.
   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

   assign bus.ev_valid  = !empty;
   assign bus.ev_code   = head.code;
   assign bus.ev_ext    = head.ext;
   assign bus.ev_break  = head.brk;
   assign bus.ev_repeat = head.rep;
   assign bus.ev_ascii  = head.ascii;
   assign ev_level      = count_q;

endmodule
